// File: rtl/fifo_pkg.sv
// Shared definitions for the programmable synchronous FIFO family.
//   read_mode_e : read-port behaviour (standard registered read or FWFT)
//   depth_of    : total entry count for a given RAM address width
//   cnt_width   : width of occupancy count and thresholds (holds 0..DEPTH)
package fifo_pkg;

    typedef enum logic {
        RD_STANDARD = 1'b0,
        RD_FWFT     = 1'b1
    } read_mode_e;

    function automatic int unsigned depth_of(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned addr_width);
        return addr_width + 32'd1;
    endfunction

endpackage

// File: rtl/ram_simple_dual.sv
// Simple dual-port RAM: one write port, one read port, one-cycle read latency.
//   clk          : clock
//   we/waddr/wdata : write port
//   re/raddr     : read request and address; rdata is valid the cycle after re
//   rdata        : read data
// DISTR=1 registers the read address in front of an asynchronous array read
// (LUT-RAM style); DISTR=0 registers the read data (block-RAM style).
module ram_simple_dual
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DISTR      = 0
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    generate
        if (DISTR != 0) begin : g_distr
            logic [ADDR_WIDTH-1:0] raddr_q;

            always_ff @(posedge clk) begin
                if (re)
                    raddr_q <= raddr;
            end

            // The FIFO never rewrites the slot held in raddr_q while its word
            // is still unconsumed, so the late array read is stable.
            assign rdata = mem[raddr_q];
        end else begin : g_block
            logic [DATA_WIDTH-1:0] rdata_q;

            always_ff @(posedge clk) begin
                if (re)
                    rdata_q <= mem[raddr];
            end

            assign rdata = rdata_q;
        end
    endgenerate

endmodule

// File: rtl/fifo_sync_prog.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds,
// full-range occupancy count, synchronous flush and sticky error flags.
//   clk, resetn            : clock, asynchronous active-low reset
//   flush                  : synchronous clear, overrides wr_en/rd_en
//   wr_en, din             : write port
//   rd_en, dout, valid     : read port (FWFT: rd_en pops the head on dout)
//   full, empty, count     : occupancy status (count covers 0..DEPTH)
//   af_thresh, ae_thresh   : thresholds for almost_full / almost_empty
//   err_clr                : clears overflow / underflow
//   overflow, underflow    : sticky error flags
// count includes words held in the FWFT prefetch stages.
module fifo_sync_prog
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned FWFT       = 0,
    parameter int unsigned DISTR      = 0
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  valid,
    output logic                  full,
    output logic                  empty,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic [ADDR_WIDTH:0]   ae_thresh,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    input  logic                  err_clr,
    output logic                  overflow,
    output logic                  underflow
);

    localparam read_mode_e  MODE    = (FWFT != 0) ? RD_FWFT : RD_STANDARD;
    localparam int unsigned CW      = cnt_width(ADDR_WIDTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(depth_of(ADDR_WIDTH));

    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [CW-1:0]         cnt;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  ram_rd;
    logic                  readable;
    logic [DATA_WIDTH-1:0] ram_q;

    assign full         = (cnt == DEPTH_C);
    assign empty        = (cnt == '0);
    assign count        = cnt;
    assign almost_full  = (cnt >= af_thresh);
    assign almost_empty = (cnt <= ae_thresh);
    assign wr_acc       = wr_en & ~full & ~flush;

    ram_simple_dual #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DISTR      (DISTR)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wptr),
        .wdata (din),
        .re    (ram_rd),
        .raddr (rptr),
        .rdata (ram_q)
    );

    generate
        if (MODE == RD_FWFT) begin : g_fwft
            // Two-stage prefetch: the RAM read register acts as a holding
            // slot (q_vld) in front of the output register (out_vld). Keeping
            // the held word in the RAM register lets pops run at full rate.
            logic                  q_vld;
            logic                  out_vld;
            logic [DATA_WIDTH-1:0] out_q;
            logic                  out_load;
            logic [CW-1:0]         staged;

            assign staged   = CW'(q_vld) + CW'(out_vld);
            assign readable = out_vld;
            assign rd_acc   = rd_en & out_vld & ~flush;
            assign out_load = q_vld & (~out_vld | rd_acc);
            // Words still in RAM = cnt - staged; fetch when the slot frees.
            assign ram_rd   = ~flush & (cnt > staged) & (~q_vld | out_load);

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    q_vld   <= 1'b0;
                    out_vld <= 1'b0;
                    out_q   <= '0;
                end else if (flush) begin
                    q_vld   <= 1'b0;
                    out_vld <= 1'b0;
                end else begin
                    q_vld   <= ram_rd | (q_vld & ~out_load);
                    out_vld <= out_load | (out_vld & ~rd_acc);
                    if (out_load)
                        out_q <= ram_q;
                end
            end

            assign valid = out_vld;
            assign dout  = out_q;
        end else begin : g_std
            logic rd_vld;

            assign readable = ~empty;
            assign rd_acc   = rd_en & ~empty & ~flush;
            assign ram_rd   = rd_acc;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn)
                    rd_vld <= 1'b0;
                else
                    rd_vld <= rd_acc;
            end

            // RAM output has no reset; dout is forced to zero outside the
            // one-cycle valid window so reset presents dout = 0.
            assign valid = rd_vld;
            assign dout  = rd_vld ? ram_q : '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (wr_acc)
                wptr <= wptr + 1'b1;
            if (ram_rd)
                rptr <= rptr + 1'b1;
            cnt <= cnt + CW'(wr_acc) - CW'(rd_acc);
        end
    end

    // Set wins over clear; flush suppresses error detection.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (wr_en & full & ~flush)     | (overflow  & ~err_clr);
            underflow <= (rd_en & ~readable & ~flush) | (underflow & ~err_clr);
        end
    end

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Self-checking bench for fifo_sync_prog: a standard-read instance and an
// FWFT instance (DEPTH 4) share one stimulus stream. A queue-based model
// tracks contents; FWFT visibility is modelled as "an entry is on dout once it
// is two edges old and its predecessor has been popped".
module tb_fifo_sync_prog;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       flush = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] din = '0;
    logic [2:0] af_t = 3'd3;
    logic [2:0] ae_t = 3'd1;

    logic [7:0] dout_o [2];
    logic [2:0] cnt_o  [2];
    logic [1:0] valid_o, full_o, empty_o, afull_o, aempty_o, ovf_o, unf_o;

    always #5 clk = ~clk;

    fifo_sync_prog #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (2),
        .FWFT       (0),
        .DISTR      (0)
    ) u_std (
        .clk (clk), .resetn (resetn), .flush (flush), .wr_en (wr_en), .din (din),
        .rd_en (rd_en), .dout (dout_o[0]), .valid (valid_o[0]), .full (full_o[0]),
        .empty (empty_o[0]), .af_thresh (af_t), .ae_thresh (ae_t),
        .almost_full (afull_o[0]), .almost_empty (aempty_o[0]), .count (cnt_o[0]),
        .err_clr (err_clr), .overflow (ovf_o[0]), .underflow (unf_o[0])
    );

    fifo_sync_prog #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (2),
        .FWFT       (1),
        .DISTR      (1)
    ) u_fwft (
        .clk (clk), .resetn (resetn), .flush (flush), .wr_en (wr_en), .din (din),
        .rd_en (rd_en), .dout (dout_o[1]), .valid (valid_o[1]), .full (full_o[1]),
        .empty (empty_o[1]), .af_thresh (af_t), .ae_thresh (ae_t),
        .almost_full (afull_o[1]), .almost_empty (aempty_o[1]), .count (cnt_o[1]),
        .err_clr (err_clr), .overflow (ovf_o[1]), .underflow (unf_o[1])
    );

    // Reference model state
    int unsigned mdata [2][$];
    int unsigned mwt   [2][$];
    int unsigned lastpop;
    int unsigned cyc;
    bit          ov [2];
    bit          un [2];
    bit          sv;
    logic [7:0]  sd;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h required 0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit fwft_vis(input int unsigned c);
        int unsigned ready;
        if (mdata[1].size() == 0) return 1'b0;
        ready = mwt[1][0] + 2;
        if (lastpop > ready) ready = lastpop;
        return ready <= c;
    endfunction

    task automatic check_all();
        int         cnt;
        bit         ev;
        logic [7:0] ed;
        for (int m = 0; m < 2; m++) begin
            cnt = mdata[m].size();
            ev  = (m == 0) ? sv : fwft_vis(cyc);
            check($sformatf("count[%0d]", m), 32'(cnt_o[m]), cnt);
            check($sformatf("full[%0d]", m), 32'(full_o[m]), 32'(cnt == DEPTH));
            check($sformatf("empty[%0d]", m), 32'(empty_o[m]), 32'(cnt == 0));
            check($sformatf("almost_full[%0d]", m), 32'(afull_o[m]), 32'(cnt >= int'(af_t)));
            check($sformatf("almost_empty[%0d]", m), 32'(aempty_o[m]), 32'(cnt <= int'(ae_t)));
            check($sformatf("overflow[%0d]", m), 32'(ovf_o[m]), 32'(ov[m]));
            check($sformatf("underflow[%0d]", m), 32'(unf_o[m]), 32'(un[m]));
            check($sformatf("valid[%0d]", m), 32'(valid_o[m]), 32'(ev));
            if (ev) begin
                ed = (m == 0) ? sd : 8'(mdata[1][0]);
                check($sformatf("dout[%0d]", m), 32'(dout_o[m]), 32'(ed));
            end
        end
    endtask

    task automatic check_reset();
        for (int m = 0; m < 2; m++) begin
            check($sformatf("rst_count[%0d]", m), 32'(cnt_o[m]), 0);
            check($sformatf("rst_empty[%0d]", m), 32'(empty_o[m]), 1);
            check($sformatf("rst_full[%0d]", m), 32'(full_o[m]), 0);
            check($sformatf("rst_valid[%0d]", m), 32'(valid_o[m]), 0);
            check($sformatf("rst_dout[%0d]", m), 32'(dout_o[m]), 0);
            check($sformatf("rst_ovf[%0d]", m), 32'(ovf_o[m]), 0);
            check($sformatf("rst_unf[%0d]", m), 32'(unf_o[m]), 0);
            check($sformatf("rst_ae[%0d]", m), 32'(aempty_o[m]), 1);
            check($sformatf("rst_af[%0d]", m), 32'(afull_o[m]), 32'(af_t == 3'd0));
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mdata[m].delete();
            mwt[m].delete();
            ov[m] = 1'b0;
            un[m] = 1'b0;
        end
        lastpop = 0;
        sv      = 1'b0;
    endtask

    // Apply the current inputs to the model, clock one edge, check outputs.
    task automatic step();
        int unsigned nc;
        int          cnt;
        bit          readable, wa, ra;
        nc = cyc + 1;
        for (int m = 0; m < 2; m++) begin
            cnt      = mdata[m].size();
            readable = (m == 0) ? (cnt > 0) : fwft_vis(cyc);
            if (flush) begin
                mdata[m].delete();
                mwt[m].delete();
                if (m == 0) sv = 1'b0;
                else        lastpop = 0;
            end else begin
                wa = wr_en && (cnt < DEPTH);
                ra = rd_en && readable;
                if (wr_en && cnt == DEPTH) ov[m] = 1'b1;
                else if (err_clr)          ov[m] = 1'b0;
                if (rd_en && !readable)    un[m] = 1'b1;
                else if (err_clr)          un[m] = 1'b0;
                if (m == 0) begin
                    sv = ra;
                    if (ra) sd = 8'(mdata[0][0]);
                end
                if (ra) begin
                    void'(mdata[m].pop_front());
                    void'(mwt[m].pop_front());
                    if (m == 1) lastpop = nc;
                end
                if (wa) begin
                    mdata[m].push_back(int'(din));
                    mwt[m].push_back(nc);
                end
            end
        end
        @(posedge clk);
        cyc = nc;
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; err_clr = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_async_reset();
        #2 resetn = 1'b0;
        #1 check_reset();
        model_reset();
        #1 resetn = 1'b1;
    endtask

    initial begin
        int pw, pr;
        cyc = 0;
        model_reset();
        #12;
        check_reset();
        resetn = 1'b1;

        // Fill A..D then drain; thresholds af=3, ae=1 exercised along the way
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; din = 8'h0A + 8'(i);
            step();
        end
        wr_en = 1'b0;
        check("std_full_after4", 32'(full_o[0]), 1);
        check("std_count_after4", 32'(cnt_o[0]), 4);
        idle(2);
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) step();
        idle(1);
        check("std_empty_after_drain", 32'(empty_o[0]), 1);
        check("fwft_empty_after_drain", 32'(empty_o[1]), 1);

        // FWFT latency: write at N, read attempt at N+1 underflows, data after N+2
        wr_en = 1'b1; din = 8'h5A;
        step();
        wr_en = 1'b0; rd_en = 1'b1;
        step();
        check("fwft_early_read_unf", 32'(unf_o[1]), 1);
        rd_en = 1'b0;
        step();
        check("fwft_valid_n2", 32'(valid_o[1]), 1);
        check("fwft_dout_n2", 32'(dout_o[1]), 32'h5A);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0; err_clr = 1'b1;
        step();
        idle(1);

        // Full FIFO with simultaneous write and read
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; din = 8'h10 + 8'(i);
            step();
        end
        idle(2);
        wr_en = 1'b1; rd_en = 1'b1; din = 8'hEE;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        check("std_full_both_count", 32'(cnt_o[0]), 3);
        check("fwft_full_both_count", 32'(cnt_o[1]), 3);
        check("std_full_both_ovf", 32'(ovf_o[0]), 1);
        check("fwft_full_both_ovf", 32'(ovf_o[1]), 1);
        idle(3);
        check("std_ovf_sticky", 32'(ovf_o[0]), 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("std_ovf_cleared", 32'(ovf_o[0]), 0);
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) step();
        idle(1);

        // Flush at count 3 with wr_en and rd_en asserted
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; din = 8'h30 + 8'(i);
            step();
        end
        idle(2);
        flush = 1'b1; wr_en = 1'b1; rd_en = 1'b1;
        step();
        flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        for (int m = 0; m < 2; m++) begin
            check($sformatf("flush_count[%0d]", m), 32'(cnt_o[m]), 0);
            check($sformatf("flush_empty[%0d]", m), 32'(empty_o[m]), 1);
            check($sformatf("flush_valid[%0d]", m), 32'(valid_o[m]), 0);
            check($sformatf("flush_ovf[%0d]", m), 32'(ovf_o[m]), 0);
            check($sformatf("flush_unf[%0d]", m), 32'(unf_o[m]), 0);
        end

        // Streaming at half occupancy across several pointer wraps
        for (int i = 0; i < 2; i++) begin
            wr_en = 1'b1; din = 8'h40 + 8'(i);
            step();
        end
        idle(2);
        for (int i = 0; i < 3 * DEPTH; i++) begin
            wr_en = 1'b1; rd_en = 1'b1; din = 8'h50 + 8'(i);
            step();
            check("std_stream_count", 32'(cnt_o[0]), 2);
        end
        idle(2);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;

        // Randomized traffic with occasional flush, error clear, threshold change
        pw = 50; pr = 50;
        for (int i = 0; i < 1500; i++) begin
            if (i % 150 == 0) begin
                pw = $urandom_range(20, 90);
                pr = $urandom_range(20, 90);
            end
            if (i % 200 == 0) begin
                af_t = 3'($urandom_range(0, 5));
                ae_t = 3'($urandom_range(0, 5));
            end
            flush   = ($urandom_range(0, 49) == 0);
            err_clr = !flush && ($urandom_range(0, 19) == 0);
            wr_en   = ($urandom_range(0, 99) < pw);
            rd_en   = ($urandom_range(0, 99) < pr);
            din     = 8'($urandom);
            step();
            if (i == 700) do_async_reset();
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
